// File: rtl/nanorv32_flow_ctrl_p.sv
// nanorv32_flow_ctrl_p: pipeline flow-control state machine for the nanorv32 core.
// Sequences the post-reset stall, branch redirect, fetch stall and data-access
// wait states. It drives the pipeline stall and PC-select controls.
// A saturating timeout counter aborts a stuck data access with a one-cycle
// bus_timeout pulse.
// Optional feature: define NANORV32_FLOW_CTRL_IRQ_EN to add the irq_req/irq_ack
// interrupt-entry redirect.
// All outputs are combinational from the state, the counters and the inputs.

module nanorv32_flow_ctrl_p #(
    parameter int RESET_STALL_CYCLES = 1,
    parameter int DATA_TIMEOUT       = 16,
    parameter int PSTATE_W           = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                branch_taken,
    input  logic                datamem_read,
    input  logic                datamem_write,
    input  logic                hreadyd,
    input  logic                codeif_cpu_ready_r,
`ifdef NANORV32_FLOW_CTRL_IRQ_EN
    input  logic                irq_req,
    output logic                irq_ack,
`endif
    output logic                force_stall_pstate,
    output logic                force_stall_pstate2,
    output logic                force_stall_reset,
    output logic                output_new_pc,
    output logic                valid_inst,
    output logic                data_access_cycle,
    output logic                bus_timeout,
    output logic [PSTATE_W-1:0] pstate_r
);

    typedef enum logic [PSTATE_W-1:0] {
        ST_RESET  = PSTATE_W'(0),
        ST_CONT   = PSTATE_W'(1),
        ST_BRANCH = PSTATE_W'(2),
        ST_STALL  = PSTATE_W'(3),
        ST_WAITLD = PSTATE_W'(4)
    } state_t;

    // Terminal counter values. When the timeout is disabled, TO_LAST is never
    // consulted because TO_EN gates the comparison.
    localparam logic [7:0]  RST_LAST = 8'(RESET_STALL_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(DATA_TIMEOUT - 1);
    localparam bit          TO_EN    = (DATA_TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        data_req;

    assign data_req = datamem_read | datamem_write;
    assign pstate_r = state_q;

    // State and counter registers; rst_n forces RESET with both counters cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Next-state, counter updates and outputs, with the priorities of each state.
    always_comb begin
        state_d             = state_q;
        rst_cnt_d           = rst_cnt_q;
        to_cnt_d            = to_cnt_q;
        force_stall_pstate  = 1'b0;
        force_stall_pstate2 = 1'b0;
        force_stall_reset   = 1'b0;
        output_new_pc       = 1'b0;
        valid_inst          = 1'b1;
        data_access_cycle   = 1'b0;
        bus_timeout         = 1'b0;
`ifdef NANORV32_FLOW_CTRL_IRQ_EN
        irq_ack             = 1'b0;
`endif
        case (state_q)
            ST_RESET: begin
                force_stall_pstate  = 1'b1;
                force_stall_pstate2 = 1'b1;
                force_stall_reset   = 1'b1;
                valid_inst          = 1'b0;
                rst_cnt_d           = rst_cnt_q + 8'd1;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_CONT;
                end
            end
            ST_CONT: begin
                to_cnt_d = '0;
                if (branch_taken) begin
                    force_stall_pstate = 1'b1;
                    output_new_pc      = 1'b1;
                    state_d            = ST_BRANCH;
                end else if (data_req) begin
                    force_stall_pstate2 = 1'b1;
                    data_access_cycle   = 1'b1;
                    state_d             = ST_WAITLD;
                end
`ifdef NANORV32_FLOW_CTRL_IRQ_EN
                else if (irq_req) begin
                    irq_ack            = 1'b1;
                    output_new_pc      = 1'b1;
                    force_stall_pstate = 1'b1;
                    state_d            = ST_BRANCH;
                end
`endif
                else if (!codeif_cpu_ready_r) begin
                    valid_inst = 1'b0;
                    state_d    = ST_STALL;
                end
            end
            ST_BRANCH: begin
                output_new_pc = 1'b1;
                if (codeif_cpu_ready_r) begin
                    state_d = ST_CONT;
                end else begin
                    force_stall_pstate = 1'b1;
                end
            end
            ST_STALL: begin
                valid_inst = 1'b0;
                if (codeif_cpu_ready_r) begin
                    state_d = ST_CONT;
                end else begin
                    force_stall_pstate = 1'b1;
                end
            end
            ST_WAITLD: begin
                if (hreadyd) begin
                    to_cnt_d = '0;
                    if (data_req) begin
                        data_access_cycle   = 1'b1;
                        force_stall_pstate2 = 1'b1;
                    end else begin
                        state_d = ST_CONT;
                    end
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    bus_timeout = 1'b1;
                    to_cnt_d    = '0;
                    state_d     = ST_CONT;
                end else begin
                    force_stall_pstate  = 1'b1;
                    force_stall_pstate2 = 1'b1;
                    if (to_cnt_q != 16'hFFFF) begin
                        to_cnt_d = to_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                to_cnt_d = '0;
                state_d  = ST_CONT;
            end
        endcase
    end

endmodule
